sdram_traffic_checker: RTL and testbench
========================================

Name: sdram_traffic_checker

Overview:
- Parametrised Avalon-MM burst master that drives the dbus port of sdram_controller.
- Writes a deterministic data pattern over a configurable address window, reads it back, compares it, and reports pass/fail with an error count.
- Used in simulation and on silicon bring-up in place of hand-written stimulus state machines; one instance per controller dbus port.

Parameters:
- ADDR_W, 25, byte address width of dbus_address.
- DATA_W, 16, data width; multiple of 8.
- BE_W, DATA_W/8, byteenable width (derived).
- BURST_W, 7, width of dbus_burstcount.
- BURST_LEN, 8, beats per burst; range 1..2^(BURST_W-1).
- NUM_BURSTS, 16, bursts per pass.
- BASE_ADDR, 0, byte address of the first beat.
- SEED, 16'h0001, pattern seed, truncated or zero-extended to DATA_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  00 write-only, 01 read-check-only, 10 write then read-check, 11 reserved (treated as 10)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of a pass
- pass  out  1  result of the last pass; held until next accepted start
- error_count  out  16  mismatched beats, saturating at 16'hFFFF
- first_err_addr  out  ADDR_W  address of the first mismatched beat
- dbus_address  out  ADDR_W  burst start byte address
- dbus_writedata  out  DATA_W  write beat data
- dbus_byteenable  out  BE_W  always all ones
- dbus_burstcount  out  BURST_W  BURST_LEN
- dbus_read  out  1  read command
- dbus_write  out  1  write beat valid
- dbus_waitrequest  in  1  slave stall
- dbus_readdata  in  DATA_W  read beat data
- dbus_readdatavalid  in  1  read beat valid

Behaviour:
- Reset values:
  - dbus_read, dbus_write, busy, done, pass: 0.
  - error_count, first_err_addr, dbus_address, dbus_writedata: 0.
  - dbus_byteenable: all ones. dbus_burstcount: BURST_LEN.
- Reset asserted mid-burst: all of the above take effect the next edge and the burst is abandoned.
- States:
  - IDLE: on start, latch mode, clear error_count and first_err_addr, load the pattern generator with SEED, go to WR_BEAT (modes 00/10/11) or RD_CMD (mode 01). dbus_write is asserted on the cycle after start is sampled.
  - WR_BEAT: dbus_write=1. dbus_address holds the burst start for all beats of the burst. A beat completes on dbus_write && !dbus_waitrequest; the pattern then advances. While stalled, address, writedata and burstcount are held stable. After the last beat of the last burst: mode 00 goes to DONE; otherwise reload the generator with SEED and go to RD_CMD.
  - RD_CMD: dbus_read=1 until !dbus_waitrequest, then go to RD_DATA. Only one read burst is outstanding at a time.
  - RD_DATA: dbus_read=0. Each dbus_readdatavalid beat is compared with the expected pattern, then the pattern advances. After BURST_LEN beats, go to RD_CMD for the next burst, or to DONE after the last burst.
  - DONE: done=1 for one cycle; pass = (error_count==0); busy=0; return to IDLE.
- Addressing: burst start = BASE_ADDR + burst_idx*BURST_LEN*BE_W, modulo 2^ADDR_W (wraps silently). The beat address used for error reporting is burst start + beat_idx*BE_W.
- Default pattern: value = SEED + global_beat_idx, modulo 2^DATA_W.
- Mismatch: error_count increments, saturating. first_err_addr is captured only on the first mismatch of the pass.
- dbus_readdatavalid outside RD_DATA counts as one error and sets first_err_addr to all ones if it is the first error.
- start while busy: ignored.
- An infinite waitrequest stall leaves the block busy indefinitely; there is no timeout.

Optional Feature:
- Macro: TRAFFIC_CHECKER_LFSR_EN.
- Defined: the pattern is a DATA_W-bit Galois LFSR (maximal-length taps per width, held in the package), loaded with SEED (SEED==0 is forced to 1) and stepped once per beat.
- Undefined: the incrementing pattern above; no LFSR logic is synthesised.

Decomposition:
- Package sdram_traffic_pkg:
  - state enum (IDLE, WR_BEAT, RD_CMD, RD_DATA, DONE);
  - mode encodings;
  - LFSR tap constants per DATA_W (8, 16, 32, 64).
- One sub-module, traffic_pattern_gen: ports clk, rst, load, step, value. It is instantiated twice, once as the write generator and once as the read/expect generator.

Test Plan:
- Defaults, NUM_BURSTS=2, zero-wait memory model, mode 10, start → writes 16 beats with data 0x0001..0x0010; burst addresses 0x0, 0x10; readback → done pulse, pass=1, error_count=0.
- Same, model corrupts the read beat at byte address 0x6 → error_count=1, first_err_addr=0x6, pass=0.
- waitrequest held high for 5 cycles on write beat 3 → address and writedata stable throughout; exactly 16 beats accepted; no data skipped or duplicated.
- rst pulsed during write beat 4 → dbus_write=0 and busy=0 next cycle; a subsequent start performs a complete clean pass.
- BASE_ADDR=2^25-16, NUM_BURSTS=2 → second burst address wraps to 0x0; pass=1.
- TRAFFIC_CHECKER_LFSR_EN defined, SEED=0 → first write beat is 0x0001 followed by the LFSR sequence; spurious readdatavalid in IDLE → error_count=1, first_err_addr all ones.

Source files
------------

// File: rtl/sdram_traffic_pkg.sv
// ============================================================================
// Module  : sdram_traffic_pkg
// Summary : Shared types and constants for the SDRAM traffic checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_traffic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BEAT = 3'd1,
    RD_CMD  = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] c_mode_write = 2'b00;
  localparam logic [1:0] c_mode_read  = 2'b01;
  localparam logic [1:0] c_mode_both  = 2'b10;
  localparam logic [1:0] c_mode_rsvd  = 2'b11;

  // Right-shifting Galois taps, maximal length for each supported width.
  localparam logic [63:0] c_taps_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] c_taps_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] c_taps_32 = 64'h0000_0000_A300_0000;
  localparam logic [63:0] c_taps_64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return c_taps_8;
      32:      return c_taps_32;
      64:      return c_taps_64;
      default: return c_taps_16;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_pattern_gen.sv
// ============================================================================
// Module  : traffic_pattern_gen
// Summary : Beat data pattern source; incrementing, or Galois LFSR when
//           TRAFFIC_CHECKER_LFSR_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_pattern_gen #(
  parameter int                DATA_W = 16,
  parameter logic [DATA_W-1:0] SEED   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] w_seed;
  logic [DATA_W-1:0] w_next;

`ifdef TRAFFIC_CHECKER_LFSR_EN
  import sdram_traffic_pkg::*;
  localparam logic [DATA_W-1:0] c_taps = DATA_W'(lfsr_taps(DATA_W));

  // An all-zero state would lock the LFSR, so a zero seed starts at 1.
  assign w_seed = (SEED == '0) ? DATA_W'(1) : SEED;
  assign w_next = (value >> 1) ^ (value[0] ? c_taps : '0);
`else
  assign w_seed = SEED;
  assign w_next = value + DATA_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= w_seed;
    end else if (step) begin
      value <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdram_traffic_checker.sv
// ============================================================================
// Module  : sdram_traffic_checker
// Summary : Avalon-MM burst master that writes, reads back and checks a
//           pattern on an SDRAM dbus port. Macro: TRAFFIC_CHECKER_LFSR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_traffic_checker
  import sdram_traffic_pkg::*;
#(
  parameter int                ADDR_W     = 25,
  parameter int                DATA_W     = 16,
  parameter int                BE_W       = DATA_W / 8,
  parameter int                BURST_W    = 7,
  parameter int                BURST_LEN  = 8,
  parameter int                NUM_BURSTS = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [15:0]       SEED       = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] dbus_address,
  output logic [DATA_W-1:0] dbus_writedata,
  output logic [BE_W-1:0]   dbus_byteenable,
  output logic [BURST_W-1:0] dbus_burstcount,
  output logic              dbus_read,
  output logic              dbus_write,
  input  logic              dbus_waitrequest,
  input  logic [DATA_W-1:0] dbus_readdata,
  input  logic              dbus_readdatavalid
);

  localparam int                  c_bidx_w      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [ADDR_W-1:0]   c_be_bytes    = ADDR_W'(BE_W);
  localparam logic [ADDR_W-1:0]   c_burst_bytes = ADDR_W'(BURST_LEN * BE_W);
  localparam logic [BURST_W-1:0]  c_last_beat   = BURST_W'(BURST_LEN - 1);
  localparam logic [c_bidx_w-1:0] c_last_burst  = c_bidx_w'(NUM_BURSTS - 1);
  localparam logic [DATA_W-1:0]   c_seed        = DATA_W'(SEED);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_mode;
  logic [BURST_W-1:0]  r_beat_idx;
  logic [c_bidx_w-1:0] r_burst_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   w_rd_value;
  logic [ADDR_W-1:0]   w_err_addr;
  logic                w_start_acc;
  logic                w_wr_acc;
  logic                w_rd_beat;
  logic                w_beat_done;
  logic                w_last_beat;
  logic                w_last_burst;
  logic                w_rd_load;
  logic                w_err;
  logic                w_enter_done;

  assign w_start_acc  = (r_state == IDLE) && start;
  assign w_wr_acc     = (r_state == WR_BEAT) && !dbus_waitrequest;
  assign w_rd_beat    = (r_state == RD_DATA) && dbus_readdatavalid;
  assign w_beat_done  = w_wr_acc || w_rd_beat;
  assign w_last_beat  = (r_beat_idx == c_last_beat);
  assign w_last_burst = (r_burst_idx == c_last_burst);
  assign w_rd_load    = w_start_acc || ((r_state == WR_BEAT) && (w_state_next == RD_CMD));
  assign w_enter_done = (r_state != DONE) && (w_state_next == DONE);

  // Any read beat outside RD_DATA is unsolicited and always an error.
  assign w_err      = dbus_readdatavalid &&
                      ((r_state != RD_DATA) || (dbus_readdata != w_rd_value));
  assign w_err_addr = (r_state == RD_DATA) ? (r_addr + ADDR_W'(r_beat_idx) * c_be_bytes) : '1;

  assign dbus_address    = r_addr;
  assign dbus_byteenable = '1;
  assign dbus_burstcount = BURST_W'(BURST_LEN);

  traffic_pattern_gen #(.DATA_W(DATA_W), .SEED(c_seed)) u_wr_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (w_start_acc),
    .step  (w_wr_acc),
    .value (dbus_writedata)
  );

  traffic_pattern_gen #(.DATA_W(DATA_W), .SEED(c_seed)) u_rd_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (w_rd_load),
    .step  (w_rd_beat),
    .value (w_rd_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    dbus_write   = 1'b0;
    dbus_read    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (mode == c_mode_read) ? RD_CMD : WR_BEAT;
        end
      end
      WR_BEAT: begin
        busy       = 1'b1;
        dbus_write = 1'b1;
        if (w_wr_acc && w_last_beat && w_last_burst) begin
          w_state_next = (r_mode == c_mode_write) ? DONE : RD_CMD;
        end
      end
      RD_CMD: begin
        busy      = 1'b1;
        dbus_read = 1'b1;
        if (!dbus_waitrequest) begin
          w_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        busy = 1'b1;
        if (w_rd_beat && w_last_beat) begin
          w_state_next = w_last_burst ? DONE : RD_CMD;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode         <= c_mode_write;
      r_beat_idx     <= '0;
      r_burst_idx    <= '0;
      r_addr         <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (w_start_acc) begin
      r_mode         <= mode;
      r_beat_idx     <= '0;
      r_burst_idx    <= '0;
      r_addr         <= BASE_ADDR;
      error_count    <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      if (w_beat_done) begin
        if (w_last_beat) begin
          r_beat_idx <= '0;
          if (w_last_burst) begin
            r_burst_idx <= '0;
            r_addr      <= BASE_ADDR;
          end else begin
            r_burst_idx <= r_burst_idx + c_bidx_w'(1);
            r_addr      <= r_addr + c_burst_bytes;
          end
        end else begin
          r_beat_idx <= r_beat_idx + BURST_W'(1);
        end
      end
      if (w_err) begin
        if (error_count != 16'hFFFF) begin
          error_count <= error_count + 16'd1;
        end
        if (error_count == 16'd0) begin
          first_err_addr <= w_err_addr;
        end
      end
      // Result is valid during the done pulse, including a final-beat error.
      if (w_enter_done) begin
        pass <= (error_count == 16'd0) && !w_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_traffic_checker.sv
// ============================================================================
// Module  : tb_sdram_traffic_checker
// Summary : Directed scoreboard bench for sdram_traffic_checker (two instances,
//           one with a wrapping base address).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_traffic_checker;

  localparam int BURST_LEN = 8;
  localparam logic [24:0] BASE0 = 25'h0;
  localparam logic [24:0] BASE1 = 25'h1FF_FFF0;
`ifdef TRAFFIC_CHECKER_LFSR_EN
  localparam logic [15:0] SEED = 16'h0000;
`else
  localparam logic [15:0] SEED = 16'h0001;
`endif

  typedef struct packed {logic [24:0] a; logic [15:0] d;} wr_exp_t;
  typedef struct packed {logic p; logic [15:0] ec; logic [24:0] fa;} res_exp_t;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [1:0]  mode;
  logic        busy[2], done[2], pass[2], dwr[2], drd[2], rdv[2], spur[2];
  logic [15:0] ec[2], wdata[2], rdata[2];
  logic [24:0] fea[2], addr[2];
  logic [1:0]  be[2];
  logic [6:0]  bc[2];
  logic        corrupt_en;
  logic [24:0] corrupt_addr;

  wr_exp_t     wq0[$], wq1[$];
  res_exp_t    rq0[$], rq1[$];
  logic [15:0] mem[int];
  int          n_pass = 0, n_fail = 0, n_total = 0;
  int          wcnt[2], dcnt[2];
  int          passes = 0;
  int          base;

  always #5 clk = ~clk;

  sdram_traffic_checker #(.NUM_BURSTS(2), .BASE_ADDR(BASE0), .SEED(SEED)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .error_count(ec[0]),
    .first_err_addr(fea[0]), .dbus_address(addr[0]), .dbus_writedata(wdata[0]),
    .dbus_byteenable(be[0]), .dbus_burstcount(bc[0]), .dbus_read(drd[0]),
    .dbus_write(dwr[0]), .dbus_waitrequest(stall), .dbus_readdata(rdata[0]),
    .dbus_readdatavalid(rdv[0])
  );

  sdram_traffic_checker #(.NUM_BURSTS(2), .BASE_ADDR(BASE1), .SEED(SEED)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .error_count(ec[1]),
    .first_err_addr(fea[1]), .dbus_address(addr[1]), .dbus_writedata(wdata[1]),
    .dbus_byteenable(be[1]), .dbus_burstcount(bc[1]), .dbus_read(drd[1]),
    .dbus_write(dwr[1]), .dbus_waitrequest(stall), .dbus_readdata(rdata[1]),
    .dbus_readdatavalid(rdv[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int i);
    logic [15:0] v;
`ifdef TRAFFIC_CHECKER_LFSR_EN
    v = (SEED == 16'h0) ? 16'h0001 : SEED;
    for (int n = 0; n < i; n++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
`else
    v = SEED + 16'(i);
`endif
    return v;
  endfunction

  function automatic int key(input int k, input logic [24:0] a);
    return k * (1 << 26) + int'(a);
  endfunction

  // Expected write beats and end-of-pass results for both instances.
  task automatic push_exp(input logic [1:0] m);
    wr_exp_t  we;
    res_exp_t re;
    logic     bad;
    for (int k = 0; k < 2; k++) begin
      if (m != 2'b01) begin
        for (int b = 0; b < 2; b++) begin
          for (int j = 0; j < BURST_LEN; j++) begin
            we.a = ((k == 0) ? BASE0 : BASE1) + 25'(b * 16);
            we.d = pat(b * BURST_LEN + j);
            if (k == 0) wq0.push_back(we); else wq1.push_back(we);
          end
        end
      end
      bad  = corrupt_en && (k == 0) && (m != 2'b00);
      re.p  = !bad;
      re.ec = bad ? 16'd1 : 16'd0;
      re.fa = bad ? corrupt_addr : 25'd0;
      if (k == 0) rq0.push_back(re); else rq1.push_back(re);
    end
  endtask

  task automatic run_start(input logic [1:0] m);
    @(posedge clk); #1;
    push_exp(m);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    passes++;
    while ((dcnt[0] < passes || dcnt[1] < passes) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_timeout", 64'(dcnt[0] >= passes && dcnt[1] >= passes), 64'd1);
  endtask

  // Memory model, write/read responder and end-of-pass monitor for one instance.
  task automatic responder(input int k);
    int          pending = 0;
    int          wbeat = 0;
    logic [24:0] raddr = '0;
    logic [15:0] d;
    wr_exp_t     we;
    res_exp_t    re;
    forever begin
      @(negedge clk);
      rdv[k] = 1'b0;
      if (rst) begin
        pending = 0;
        wbeat   = 0;
        continue;
      end
      if (spur[k]) begin
        rdv[k]   = 1'b1;
        rdata[k] = 16'h0;
        spur[k]  = 1'b0;
      end else if (pending > 0) begin
        d = mem.exists(key(k, raddr)) ? mem[key(k, raddr)] : 16'h0;
        if (corrupt_en && k == 0 && raddr == corrupt_addr) d = d ^ 16'h8000;
        rdv[k]   = 1'b1;
        rdata[k] = d;
        raddr    = raddr + 25'd2;
        pending--;
      end
      if (dwr[k] && !stall) begin
        we = '0;
        if (k == 0) begin
          check("u0_wq_nonempty", 64'(wq0.size() != 0), 64'd1);
          if (wq0.size() != 0) we = wq0.pop_front();
        end else begin
          check("u1_wq_nonempty", 64'(wq1.size() != 0), 64'd1);
          if (wq1.size() != 0) we = wq1.pop_front();
        end
        check($sformatf("u%0d_wr_addr", k), 64'(addr[k]), 64'(we.a));
        check($sformatf("u%0d_wr_data", k), 64'(wdata[k]), 64'(we.d));
        mem[key(k, addr[k] + 25'(2 * wbeat))] = wdata[k];
        wbeat = (wbeat + 1) % BURST_LEN;
        wcnt[k]++;
      end
      if (drd[k] && !stall) begin
        pending = BURST_LEN;
        raddr   = addr[k];
      end
      if (done[k]) begin
        re = '0;
        if (k == 0) begin
          check("u0_rq_nonempty", 64'(rq0.size() != 0), 64'd1);
          if (rq0.size() != 0) re = rq0.pop_front();
          check("u0_wr_beats_left", 64'(wq0.size()), 64'd0);
        end else begin
          check("u1_rq_nonempty", 64'(rq1.size() != 0), 64'd1);
          if (rq1.size() != 0) re = rq1.pop_front();
          check("u1_wr_beats_left", 64'(wq1.size()), 64'd0);
        end
        check($sformatf("u%0d_pass", k), 64'(pass[k]), 64'(re.p));
        check($sformatf("u%0d_error_count", k), 64'(ec[k]), 64'(re.ec));
        check($sformatf("u%0d_first_err_addr", k), 64'(fea[k]), 64'(re.fa));
        check($sformatf("u%0d_busy_at_done", k), 64'(busy[k]), 64'd0);
        dcnt[k]++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; stall = 1'b0;
    corrupt_en = 1'b0; corrupt_addr = '0;
    for (int k = 0; k < 2; k++) begin
      rdv[k] = 1'b0; rdata[k] = '0; spur[k] = 1'b0; wcnt[k] = 0; dcnt[k] = 0;
    end
    fork
      responder(0);
      responder(1);
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_write", 64'(dwr[k]), 64'd0);
      check("rst_read", 64'(drd[k]), 64'd0);
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_done", 64'(done[k]), 64'd0);
      check("rst_pass", 64'(pass[k]), 64'd0);
      check("rst_error_count", 64'(ec[k]), 64'd0);
      check("rst_first_err_addr", 64'(fea[k]), 64'd0);
      check("rst_address", 64'(addr[k]), 64'd0);
      check("rst_writedata", 64'(wdata[k]), 64'd0);
      check("rst_byteenable", 64'(be[k]), 64'h3);
      check("rst_burstcount", 64'(bc[k]), 64'd8);
    end

    // Clean write+check pass; a start pulse while busy must be ignored.
    run_start(2'b10);
    @(negedge clk);
    check("first_cycle_busy", 64'(busy[0]), 64'd1);
    check("first_cycle_write", 64'(dwr[0]), 64'd1);
    check("first_wdata", 64'(wdata[0]), 64'h0001);
    check("u1_first_addr", 64'(addr[1]), 64'(BASE1));
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Five-cycle stall on the third write beat.
    base = wcnt[0];
    run_start(2'b10);
    for (int c = 0; c < 100 && wcnt[0] < base + 2; c++) begin
      @(posedge clk); #1;
    end
    check("stall_beat_reached", 64'(wcnt[0]), 64'(base + 2));
    stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_write", 64'(dwr[0]), 64'd1);
      check("stall_addr", 64'(addr[0]), 64'(BASE0));
      check("stall_wdata", 64'(wdata[0]), 64'(pat(2)));
      @(posedge clk); #1;
    end
    stall = 1'b0;
    wait_done();

    // Corrupted read beat at byte address 0x6 on instance 0.
    corrupt_en = 1'b1; corrupt_addr = 25'h6;
    run_start(2'b10);
    wait_done();
    corrupt_en = 1'b0;

    run_start(2'b01);
    wait_done();
    run_start(2'b00);
    wait_done();

    // Reset during the fourth write beat.
    base = wcnt[0];
    run_start(2'b10);
    for (int c = 0; c < 100 && wcnt[0] < base + 3; c++) begin
      @(posedge clk); #1;
    end
    check("rst_beat_reached", 64'(wcnt[0]), 64'(base + 3));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("midrst_write", 64'(dwr[k]), 64'd0);
      check("midrst_busy", 64'(busy[k]), 64'd0);
      check("midrst_pass", 64'(pass[k]), 64'd0);
    end

    run_start(2'b11);
    wait_done();

    // Unsolicited read beat while idle.
    @(posedge clk); #1;
    spur[0] = 1'b1; spur[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("spur_error_count", 64'(ec[k]), 64'd1);
      check("spur_first_err_addr", 64'(fea[k]), 64'h1FF_FFFF);
      check("spur_pass_held", 64'(pass[k]), 64'd1);
      check("spur_busy", 64'(busy[k]), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
